// File: rtl/rr_handshake_arbiter_if.sv
// rr_handshake_arbiter_if: N upstream ready/valid channels plus one shared downstream channel
//   m_valid/m_data/m_last/m_ready : per-requester upstream handshake, requester i in slice i
//   s_valid/s_data/s_last/s_id/s_ready : downstream handshake, s_id names the source requester
//   master : requester/sink side (drives m_* payload and s_ready)
//   slave  : arbiter side
interface rr_handshake_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int N     = 4
);
   localparam int IDW = (N > 1) ? $clog2(N) : 1;
   logic [N-1:0]       m_valid;
   logic [N*WIDTH-1:0] m_data;
   logic [N-1:0]       m_last;
   logic [N-1:0]       m_ready;
   logic               s_valid;
   logic [WIDTH-1:0]   s_data;
   logic               s_last;
   logic [IDW-1:0]     s_id;
   logic               s_ready;
   modport master (
      output m_valid, m_data, m_last, s_ready,
      input  m_ready, s_valid, s_data, s_last, s_id
   );
   modport slave (
      input  m_valid, m_data, m_last, s_ready,
      output m_ready, s_valid, s_data, s_last, s_id
   );
endinterface

// File: rtl/rr_handshake_arbiter.sv
// rr_handshake_arbiter: packet-locked round-robin arbiter feeding one registered main+skid output stage
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : rr_handshake_arbiter_if.slave, upstream m_* channels and downstream s_* channel
module rr_handshake_arbiter #(
   parameter int WIDTH = 8,
   parameter int N     = 4
) (
   input logic                   clk,
   input logic                   rst,
   rr_handshake_arbiter_if.slave bus
);
   localparam int IDW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic {IDLE, LOCK} state_t;
   state_t           r_state, w_next;
   logic [IDW-1:0]   r_grant, r_ptr, w_pick, w_j;
   logic [N-1:0]     w_ready;
   logic             w_acc, w_last, w_pop;
   logic [WIDTH-1:0] w_data;
   logic             r_out_v, r_out_l, r_skid_v, r_skid_l;
   logic [WIDTH-1:0] r_out_d, r_skid_d;
   logic [IDW-1:0]   r_out_id, r_skid_id;
   // Descending scan so the requester closest after r_ptr is written last and wins.
   always_comb begin
      w_pick = r_ptr;
      w_j    = '0;
      for (int k = N; k >= 1; k--) begin
         w_j = IDW'((32'(r_ptr) + 32'(k)) % N);
         if (bus.m_valid[w_j]) w_pick = w_j;
      end
   end
   assign w_data = WIDTH'(bus.m_data >> (32'(r_grant) * WIDTH));
   assign w_last = bus.m_last[r_grant];
   assign w_acc  = bus.m_valid[r_grant] & w_ready[r_grant];
   assign w_pop  = r_out_v & bus.s_ready;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_ptr   <= IDW'(N - 1);
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && |bus.m_valid) r_grant <= w_pick;
         if (w_acc && w_last) r_ptr <= r_grant;
      end
   end
   always_comb begin
      w_next = (r_state == IDLE) ? (|bus.m_valid ? LOCK : IDLE) : ((w_acc && w_last) ? IDLE : LOCK);
   end
   // Ready depends only on flops: a full skid blocks the granted requester.
   always_comb begin
      w_ready = (r_state == LOCK && !r_skid_v) ? (N'(1) << r_grant) : '0;
   end
   assign bus.m_ready = w_ready;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_v   <= 1'b0;
         r_out_d   <= '0;
         r_out_l   <= 1'b0;
         r_out_id  <= '0;
         r_skid_v  <= 1'b0;
         r_skid_d  <= '0;
         r_skid_l  <= 1'b0;
         r_skid_id <= '0;
      end else if (w_acc && (!r_out_v || w_pop)) begin
         r_out_v  <= 1'b1;
         r_out_d  <= w_data;
         r_out_l  <= w_last;
         r_out_id <= r_grant;
      end else if (w_acc) begin
         r_skid_v  <= 1'b1;
         r_skid_d  <= w_data;
         r_skid_l  <= w_last;
         r_skid_id <= r_grant;
      end else if (w_pop && r_skid_v) begin
         r_out_d  <= r_skid_d;
         r_out_l  <= r_skid_l;
         r_out_id <= r_skid_id;
         r_skid_v <= 1'b0;
      end else if (w_pop) begin
         r_out_v <= 1'b0;
      end
   end
   assign bus.s_valid = r_out_v;
   assign bus.s_data  = r_out_d;
   assign bus.s_last  = r_out_l;
   assign bus.s_id    = r_out_id;
endmodule
